// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e : FSM state (FETCH issues requests, HOLD parks a word
//                   that arrived while the issue stage was stalled)
//   NOP_INSTR_DEF : default bubble instruction (sll $0,$0,0)
//   PCT_*         : encodings of id_if_selpctype
//   pc_plus4      : sequential next-PC, wraps modulo 2^32
//   word_align    : clears bits [1:0] of a redirect target
package fetch_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam logic [1:0] PCT_BRANCH = 2'b00;
  localparam logic [1:0] PCT_JREG   = 2'b01;
  localparam logic [1:0] PCT_JIDX   = 2'b10;
  localparam logic [1:0] PCT_EXC    = 2'b11;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_mux.sv
// fetch_pc_mux: combinational redirect-target select.
//   selpctype : 00 branch target, 01 jump-register, 10 jump-index,
//               11 exception vector
//   pcimd2ext, rega, pcindex : candidate targets from decode
//   target    : selected target, word aligned
module fetch_pc_mux
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic [1:0]  selpctype,
  input  logic [31:0] pcimd2ext,
  input  logic [31:0] rega,
  input  logic [31:0] pcindex,
  output logic [31:0] target
);

  logic [31:0] raw_target;

  always_comb begin
    raw_target = pcimd2ext;
    case (selpctype)
      PCT_BRANCH: raw_target = pcimd2ext;
      PCT_JREG:   raw_target = rega;
      PCT_JIDX:   raw_target = pcindex;
      PCT_EXC:    raw_target = EXC_VECTOR;
      default:    raw_target = pcimd2ext;
    endcase
  end

  // Instructions are word aligned; a misaligned register jump is silently
  // truncated rather than trapped here.
  assign target = word_align(raw_target);

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding decode.
//   clock, reset (async, active-low)
//   id_if_selpcsource/id_if_selpctype/id_if_rega/id_if_pcimd2ext/
//   id_if_pcindex : redirect request and candidate targets from decode
//   iss_stall     : issue stall, decode holds its inputs while high
//   if_mem_req/if_mem_addr, mem_if_ready/mem_if_data : instruction memory
//   if_id_instruc/if_id_nextpc : registered instruction and its PC+4
//   dbg_state     : current FSM state
//
// Memory handshake: a word transfers in exactly the cycles where
// if_mem_req and mem_if_ready are both high; mem_if_data then belongs to
// if_mem_addr of that same cycle. There is never an outstanding request,
// so the address may change freely from cycle to cycle.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         id_if_selpcsource,
  input  logic [1:0]   id_if_selpctype,
  input  logic [31:0]  id_if_rega,
  input  logic [31:0]  id_if_pcimd2ext,
  input  logic [31:0]  id_if_pcindex,
  input  logic         iss_stall,
  output logic         if_mem_req,
  output logic [31:0]  if_mem_addr,
  input  logic         mem_if_ready,
  input  logic [31:0]  mem_if_data,
  output logic [31:0]  if_id_instruc,
  output logic [31:0]  if_id_nextpc,
  output fetch_state_e dbg_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_buf_q, hold_buf_d;
  logic [31:0]  instruc_q, instruc_d;
  logic [31:0]  nextpc_q, nextpc_d;
  logic [31:0]  target;
  logic [31:0]  pc_inc;
  logic         redir;

  fetch_pc_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_mux (
    .selpctype (id_if_selpctype),
    .pcimd2ext (id_if_pcimd2ext),
    .rega      (id_if_rega),
    .pcindex   (id_if_pcindex),
    .target    (target)
  );

  // Decode is frozen under a stall, so a redirect it shows then is stale
  // until the stall drops; it will be re-presented.
  assign redir  = id_if_selpcsource & ~iss_stall;
  assign pc_inc = pc_plus4(pc_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_buf_d = hold_buf_q;
    instruc_d  = instruc_q;
    nextpc_d   = nextpc_q;
    case (state_q)
      ST_FETCH: begin
        if (redir) begin
          // Redirect wins over any word returned this cycle.
          pc_d      = target;
          instruc_d = NOP_INSTR;
          nextpc_d  = target;
        end else if (iss_stall) begin
          // Park a word that arrives under stall so it is not lost.
          if (mem_if_ready) begin
            hold_buf_d = mem_if_data;
            state_d    = ST_HOLD;
          end
        end else if (mem_if_ready) begin
          instruc_d = mem_if_data;
          nextpc_d  = pc_inc;
          pc_d      = pc_inc;
        end else begin
          // Bubble: nextpc points at the instruction still being fetched.
          instruc_d = NOP_INSTR;
          nextpc_d  = pc_q;
        end
      end
      ST_HOLD: begin
        if (iss_stall) begin
          state_d = ST_HOLD;
        end else if (redir) begin
          pc_d      = target;
          instruc_d = NOP_INSTR;
          nextpc_d  = target;
          state_d   = ST_FETCH;
        end else begin
          instruc_d = hold_buf_q;
          nextpc_d  = pc_inc;
          pc_d      = pc_inc;
          state_d   = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      hold_buf_q <= 32'h0000_0000;
      instruc_q  <= NOP_INSTR;
      nextpc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_buf_q <= hold_buf_d;
      instruc_q  <= instruc_d;
      nextpc_q   <= nextpc_d;
    end
  end

  // Gating with reset keeps the request low for the whole reset period,
  // independent of the registered state.
  assign if_mem_req    = reset & (state_q == ST_FETCH);
  assign if_mem_addr   = pc_q;
  assign if_id_instruc = instruc_q;
  assign if_id_nextpc  = nextpc_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int W = 97;  // {req, addr, instruc, nextpc}

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         id_if_selpcsource = 1'b0;
  logic [1:0]   id_if_selpctype = 2'b00;
  logic [31:0]  id_if_rega = 32'h0;
  logic [31:0]  id_if_pcimd2ext = 32'h0;
  logic [31:0]  id_if_pcindex = 32'h0;
  logic         iss_stall = 1'b0;
  logic         if_mem_req;
  logic [31:0]  if_mem_addr;
  logic         mem_if_ready = 1'b0;
  logic [31:0]  mem_if_data;
  logic [31:0]  if_id_instruc;
  logic [31:0]  if_id_nextpc;
  fetch_state_e dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage dut (
    .clock             (clock),
    .reset             (reset),
    .id_if_selpcsource (id_if_selpcsource),
    .id_if_selpctype   (id_if_selpctype),
    .id_if_rega        (id_if_rega),
    .id_if_pcimd2ext   (id_if_pcimd2ext),
    .id_if_pcindex     (id_if_pcindex),
    .iss_stall         (iss_stall),
    .if_mem_req        (if_mem_req),
    .if_mem_addr       (if_mem_addr),
    .mem_if_ready      (mem_if_ready),
    .mem_if_data       (mem_if_data),
    .if_id_instruc     (if_id_instruc),
    .if_id_nextpc      (if_id_nextpc),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- memory: word at address a is a ^ 8C00_0000 --------
  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  assign mem_if_data = mw(if_mem_addr);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Drives this cycle's inputs and records what the DUT must show during
  // this same cycle (registered outputs from the previous edge plus the
  // combinational request/address).
  task automatic drive(input logic stall, input logic sel, input logic [1:0] typ,
                       input logic rdy, input logic [31:0] opnd,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_next);
    iss_stall         = stall;
    id_if_selpcsource = sel;
    id_if_selpctype   = typ;
    mem_if_ready      = rdy;
    id_if_pcimd2ext   = (typ == PCT_BRANCH) ? opnd : 32'h0BAD_0010;
    id_if_rega        = (typ == PCT_JREG)   ? opnd : 32'h0EEE_0020;
    id_if_pcindex     = (typ == PCT_JIDX)   ? opnd : 32'h0CCC_0030;
    exp_q.push_back({e_req, e_addr, e_instr, e_next});
  endtask

  task automatic step(input logic stall, input logic sel, input logic [1:0] typ,
                      input logic rdy, input logic [31:0] opnd,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_instr, input logic [31:0] e_next);
    drive(stall, sel, typ, rdy, opnd, e_req, e_addr, e_instr, e_next);
    @(posedge clock);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("if_mem_req",    {31'b0, if_mem_req}, {31'b0, e[96]});
      check("if_mem_addr",   if_mem_addr,   e[95:64]);
      check("if_id_instruc", if_id_instruc, e[63:32]);
      check("if_id_nextpc",  if_id_nextpc,  e[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #3;
    check("rst_req",     {31'b0, if_mem_req}, 32'h0);
    check("rst_addr",    if_mem_addr,   32'h0);
    check("rst_instruc", if_id_instruc, 32'h0);
    check("rst_nextpc",  if_id_nextpc,  32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // straight-line fetch, one word per cycle
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h00, 32'h0,      32'h00);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h04, mw(32'h00), 32'h04);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h08, mw(32'h04), 32'h08);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h0C, mw(32'h08), 32'h0C);
    // ready low for three cycles at pc 0x10
    step(0, 0, 2'd0, 0, 32'h0, 1, 32'h10, mw(32'h0C), 32'h10);
    step(0, 0, 2'd0, 0, 32'h0, 1, 32'h10, 32'h0,      32'h10);
    step(0, 0, 2'd0, 0, 32'h0, 1, 32'h10, 32'h0,      32'h10);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h10, 32'h0,      32'h10);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h14, mw(32'h10), 32'h14);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h18, mw(32'h14), 32'h18);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h1C, mw(32'h18), 32'h1C);
    // stall with ready at 0x20 -> HOLD, outputs frozen
    step(1, 0, 2'd0, 1, 32'h0, 1, 32'h20, mw(32'h1C), 32'h20);
    step(1, 0, 2'd0, 1, 32'h0, 0, 32'h20, mw(32'h1C), 32'h20);
    step(0, 0, 2'd0, 0, 32'h0, 0, 32'h20, mw(32'h1C), 32'h20);
    // jump-register to 0x103 -> 0x100, one bubble
    step(0, 1, 2'd1, 1, 32'h103, 1, 32'h24, mw(32'h20), 32'h24);
    step(0, 0, 2'd0, 1, 32'h0,   1, 32'h100, 32'h0,      32'h100);
    // stall parks word(0x104), then branch redirect out of HOLD
    step(1, 0, 2'd0, 1, 32'h0,   1, 32'h104, mw(32'h100), 32'h104);
    step(0, 1, 2'd0, 1, 32'h202, 0, 32'h104, mw(32'h100), 32'h104);
    // jump-index under stall: ignored, taken once the stall drops
    step(1, 1, 2'd2, 1, 32'h300, 1, 32'h200, 32'h0, 32'h200);
    step(1, 1, 2'd2, 1, 32'h300, 0, 32'h200, 32'h0, 32'h200);
    step(0, 1, 2'd2, 0, 32'h300, 0, 32'h200, 32'h0, 32'h200);
    step(0, 0, 2'd0, 1, 32'h0,   1, 32'h300, 32'h0, 32'h300);
    // exception redirect under stall (not ready): ignored, then taken
    step(1, 1, 2'd3, 0, 32'h0, 1, 32'h304, mw(32'h300), 32'h304);
    step(0, 1, 2'd3, 1, 32'h0, 1, 32'h304, mw(32'h300), 32'h304);
    // jump to 0xFFFF_FFFF (aligned to ..FC), then wrap to 0
    step(0, 1, 2'd1, 1, 32'hFFFF_FFFF, 1, 32'h40, 32'h0, 32'h40);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
    step(1, 0, 2'd0, 1, 32'h0, 1, 32'h0, mw(32'hFFFF_FFFC), 32'h0);
    // in HOLD, then asynchronous reset mid-cycle
    drive(1, 0, 2'd0, 1, 32'h0, 0, 32'h0, mw(32'hFFFF_FFFC), 32'h0);
    #6;
    reset = 1'b0;
    #1;
    check("async_rst_instruc", if_id_instruc, 32'h0);
    check("async_rst_nextpc",  if_id_nextpc,  32'h0);
    check("async_rst_req",     {31'b0, if_mem_req}, 32'h0);
    check("async_rst_addr",    if_mem_addr,   32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    // HOLD contents gone: fetching restarts at RESET_PC
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h00, 32'h0,      32'h00);
    step(0, 0, 2'd0, 1, 32'h0, 1, 32'h04, mw(32'h00), 32'h04);

    repeat (2) @(posedge clock);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage, directly upstream of the decode stage. Holds the program counter, requests instructions from instruction memory over a ready-qualified interface, and delivers `if_id_instruc`/`if_id_nextpc` to decode. Applies the redirect (branch/jump target) decode resolves combinationally. Honours the issue-stage stall that freezes decode.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `EXC_VECTOR`, 32'h0000_0040, target for `selpctype` 2'b11.
- `NOP_INSTR`, 32'h0000_0000, bubble instruction (sll $0,$0,0; decodes with no branch and no write side effects).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `id_if_selpcsource`  in  1  decode requests redirect.
- `id_if_selpctype`  in  2  00 = `id_if_pcimd2ext`, 01 = `id_if_rega`, 10 = `id_if_pcindex`, 11 = `EXC_VECTOR`.
- `id_if_rega`  in  32  jump-register target.
- `id_if_pcimd2ext`  in  32  branch target.
- `id_if_pcindex`  in  32  jump-index target.
- `iss_stall`  in  1  issue stall; decode holds its input.
- `if_mem_req`  out  1  fetch request.
- `if_mem_addr`  out  32  fetch address; always equals `pc`.
- `mem_if_ready`  in  1  `mem_if_data` is valid for `if_mem_addr` this cycle.
- `mem_if_data`  in  32  instruction word.
- `if_id_instruc`  out  32  instruction to decode (registered).
- `if_id_nextpc`  out  32  address of that instruction + 4 (registered).

## Operation
- State: `pc`, `buf` (32 bits), FSM {FETCH, HOLD}, plus the output registers.
- Memory protocol has no outstanding transactions.
  - A word transfers only in a cycle with `if_mem_req` and `mem_if_ready` both high.
  - The address may change in any cycle.
- `if_mem_req` = `reset` AND (state == FETCH).
- Redirect condition `redir` = `id_if_selpcsource` AND NOT `iss_stall`.
  - Target is selected by `selpctype`.
  - Target bits [1:0] are forced to 00.
- Redirect has priority over memory data. Data returned in the redirect cycle is discarded.
- FETCH:
  - `redir`: `pc` ← target; `if_id_instruc` ← NOP; `if_id_nextpc` ← target; stay in FETCH.
  - `iss_stall`, ready: `buf` ← data; go to HOLD; if_id registers hold.
  - `iss_stall`, not ready: everything holds.
  - not stalled, ready: `if_id_instruc` ← data; `if_id_nextpc` ← pc+4; `pc` ← pc+4.
  - not stalled, not ready: `if_id_instruc` ← NOP; `if_id_nextpc` ← pc (bubble).
- HOLD (no request):
  - `iss_stall`: hold.
  - `redir`: discard `buf`; redirect as in FETCH; go to FETCH.
  - else: `if_id_instruc` ← `buf`; `if_id_nextpc` ← pc+4; `pc` ← pc+4; go to FETCH.
- While `iss_stall` is high, redirects are ignored. Decode re-presents the same branch after the stall drops.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC → 0.

## Timing
- Reset (asynchronous, while `reset` = 0):
  - `pc` = `RESET_PC`; state = FETCH; `buf` = 0.
  - `if_id_instruc` = `NOP_INSTR`; `if_id_nextpc` = `RESET_PC`.
  - `if_mem_req` = 0.
- First request is in the first cycle after `reset` deasserts.
- Reset mid-operation aborts everything, including the HOLD contents.
- Fetch latency: address presented with ready in cycle N → word on `if_id_instruc` in N+1.
- Redirect penalty: branch in decode in cycle N → target address in N+1 → target instruction at decode in N+2. Exactly one NOP bubble is inserted at N+1.
- Back-to-back ready with no stall gives one instruction per cycle.
- Stall and ready arriving together are never lost: the word goes to `buf`.

## Structure
- Package `fetch_pkg`:
  - FSM state enum.
  - `NOP_INSTR` default.
  - `selpctype` encodings (`PCT_BRANCH`, `PCT_JREG`, `PCT_JIDX`, `PCT_EXC`).
- Sub-module `fetch_pc_mux`: combinational target select and [1:0] masking.
- FSM, `pc`, `buf` and output registers live in `fetch_stage`.

## Test plan
- Reset, ready tied 1, no stall:
  - addresses 0, 4, 8…
  - `if_id_nextpc` 4, 8, 12… one per cycle after the first.
- Ready low for 3 cycles at pc = 0x10: three NOPs with `if_id_nextpc` = 0x10; 0x10's word then appears with `nextpc` 0x14.
- `iss_stall` high with ready at pc = 0x20: HOLD, `if_mem_req` = 0, outputs frozen; stall released → word(0x20), `nextpc` 0x24, fetch resumes at 0x24.
- Redirect `selpctype` = 01, `rega` = 0x103: next address 0x100; one NOP with `nextpc` 0x100; word(0x100) follows.
- Redirect while in HOLD, and redirect asserted during a stall: buffered word dropped; a redirect under stall is ignored until the stall drops, then taken.
- Wrap at 0xFFFF_FFFC → `nextpc` 0; reset asserted in HOLD → outputs NOP / `RESET_PC` immediately, without waiting for a clock edge.
